uart_tx_sched: RTL
==================

# uart_tx_sched

Round-robin transmit scheduler that shares the single UART transmitter between `NREQ` byte producers, e.g. the CPU register path and a debug/trace source. It accepts one byte per valid/ready handshake and drives the transmitter's `tx_start`/`d_tx` inputs. It waits for `tx_done`, then enforces a low gap on `tx_start` so the tick-clocked transmitter sees the edge. A watchdog aborts a frame whose `tx_done` never arrives.

## Interface
- `NREQ`, 2: number of requesters, at least 2.
- `TIMEOUT`, 1_000_000: maximum clk cycles in WAIT before abort.
- `GAP`, 64: clk cycles `tx_start` stays low after each frame. Must exceed one baud-tick period (dvsr+1).
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: requester i has a byte.
- `req_data`  in  8*NREQ: byte i at bits [8i+7:8i].
- `req_ready`  out  NREQ: one-hot grant; the byte transfers on a clk edge where valid[i] and ready[i] are both high.
- `tx_start`  out  1: level start request to the transmitter.
- `d_tx`  out  8: byte being transmitted; stable while `tx_start` is high.
- `tx_done`  in  1: frame-complete pulse, already in the clk domain.
- `clr_err`  in  1: clears `timeout_err`.
- `busy`  out  1: high in WAIT and GAP.
- `grant_id`  out  $clog2(NREQ): index of the last accepted requester.
- `timeout_err`  out  1: sticky; set on watchdog abort.

## Operation
- Reset values: state IDLE, `tx_start`=0, `d_tx`=0, `req_ready`=0, `busy`=0, `grant_id`=NREQ-1, `timeout_err`=0, both counters 0.
- Round-robin search starts at `grant_id`+1 mod NREQ and picks the first requester with valid high. After reset, requester 0 has top priority.
- `req_ready` is combinational. It is high only in IDLE, only for the selected requester, and at most one bit is set.
- IDLE, with any valid high: on the handshake edge, latch the byte into `d_tx`, update `grant_id`, set `tx_start`=1 and go to WAIT.
- WAIT: `tx_start` held at 1 and the timeout counter increments each cycle.
  - `tx_done`=1: `tx_start`=0, go to GAP.
  - Counter reaches TIMEOUT-1 without `tx_done`: `tx_start`=0, `timeout_err`=1, go to GAP.
  - If `tx_done` and the timeout land in the same cycle, `tx_done` wins and `timeout_err` is not set.
- GAP: the gap counter counts GAP cycles, then the block returns to IDLE. Valid requests are not accepted during GAP.
- `tx_done` arriving outside WAIT is ignored.
- `clr_err`=1 clears `timeout_err` the next cycle. If a new timeout occurs in that same cycle, the set wins.
- Requesters must hold valid and data stable until ready. Dropping valid before ready is allowed; that request is simply lost.
- Reset asserted mid-frame drops the byte immediately, with all outputs forced to their reset values.

## Timing
- Acceptance at edge N: `tx_start` and `d_tx` are valid at N+1.
- `tx_done` sampled at edge M: `tx_start`=0 and `busy` stays 1 from M+1.
- The earliest next acceptance is at edge M+GAP+1, so `busy` falls GAP cycles after `tx_start` falls.
- Timeout counter width is $clog2(TIMEOUT); gap counter width is $clog2(GAP). Both counters clear on entering their state and never wrap.
- Back-to-back traffic throughput is one byte per (frame time + GAP + 1) cycles.

## Structure
- Package `uart_pkg` holds:
  - the `sched_state_t` enum {IDLE, WAIT, GAP};
  - the default TIMEOUT/GAP localparams;
  - the `UART_DBIT`=8 constant.
- Sub-module `rr_arbiter`: combinational rotate-priority select. Inputs are `req_valid` and the last grant; outputs are a one-hot grant and an index.
- The scheduler holds the FSM, both counters, the data latch and the error flag.

## Test plan
- Single byte: req_valid[0]=1, data 0x55.
  - Expect ready[0] for one cycle, then `tx_start`=1 with `d_tx`=0x55 next cycle.
  - `tx_done` pulse → `tx_start`=0, and `busy` drops GAP cycles later.
- Fairness: both valid continuously with data 0xA0/0xB1, `tx_done` 20 cycles after each start.
  - Expect the grant order 0,1,0,1 and `d_tx` alternating 0xA0, 0xB1, 0xA0, 0xB1.
- Timeout: accept 0x3C, never pulse `tx_done`.
  - After TIMEOUT cycles (bench overrides TIMEOUT=100): `tx_start`=0, `timeout_err`=1.
  - `clr_err` → `timeout_err`=0, and the next request is served.
- Tie: `tx_done` and the final timeout cycle coincide → `timeout_err` stays 0.
- Spurious `tx_done` in IDLE and in GAP → no state change and no `tx_start`.
- Reset mid-WAIT (0x7E in flight) → `tx_start`=0 and `busy`=0 immediately. After release, requester 0 is served first.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared types and constants for the UART transmit scheduler
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  localparam int DEF_TIMEOUT = 1_000_000;
  localparam int DEF_GAP     = 64;
  localparam int UART_DBIT   = 8;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational rotate-priority select, search starts after last_id
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req_valid,
  input  logic [$clog2(NREQ)-1:0] last_id,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IW = $clog2(NREQ);

  int cand;

  // Walk from the farthest candidate to the nearest so the nearest valid one wins.
  always_comb begin
    grant     = '0;
    grant_idx = last_id;
    cand      = 0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = (int'(last_id) + i) % NREQ;
      if (req_valid[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched : round-robin scheduler sharing one UART transmitter, with gap and watchdog
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int GAP     = DEF_GAP
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [UART_DBIT*NREQ-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      tx_start,
  output logic [UART_DBIT-1:0]      d_tx,
  input  logic                      tx_done,
  input  logic                      clr_err,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      timeout_err
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP);

  sched_state_t    state;
  logic [TW-1:0]   to_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [NREQ-1:0] sel_grant;
  logic [IW-1:0]   sel_idx;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_valid (req_valid),
    .last_id   (grant_id),
    .grant     (sel_grant),
    .grant_idx (sel_idx)
  );

  // Gated by reset so the grant reads zero while the block is held in reset.
  assign req_ready = sel_grant & {NREQ{(state == uart_pkg::IDLE) && !reset}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= uart_pkg::IDLE;
      tx_start    <= 1'b0;
      d_tx        <= '0;
      busy        <= 1'b0;
      grant_id    <= IW'(NREQ - 1);
      timeout_err <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      // A timeout abort later in this block overrides the clear.
      if (clr_err)
        timeout_err <= 1'b0;
      case (state)
        uart_pkg::IDLE: begin
          if (|req_valid) begin
            d_tx     <= req_data[int'(sel_idx)*UART_DBIT +: UART_DBIT];
            grant_id <= sel_idx;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            to_cnt   <= '0;
            state    <= uart_pkg::WAIT;
          end
        end
        uart_pkg::WAIT: begin
          if (tx_done) begin
            tx_start <= 1'b0;
            gap_cnt  <= '0;
            state    <= uart_pkg::GAP;
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            tx_start    <= 1'b0;
            timeout_err <= 1'b1;
            gap_cnt     <= '0;
            state       <= uart_pkg::GAP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        uart_pkg::GAP: begin
          if (gap_cnt == GW'(GAP - 1)) begin
            busy  <= 1'b0;
            state <= uart_pkg::IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          tx_start <= 1'b0;
          busy     <= 1'b0;
          state    <= uart_pkg::IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
